// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU front-end widths and the instruction queue entry type
package cpu_pkg;

  localparam int DATA_WIDTH   = 32;
  localparam int ADDR_WIDTH   = 32;
  localparam int OPCODE_WIDTH = 6;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [DATA_WIDTH-1:0] instruction;
  } iq_entry_t;

endpackage

// File: rtl/iq_storage.sv
// rtl/iq_storage.sv - instruction queue register file
// One synchronous write port, one combinational read port, cleared to zero on reset.
module iq_storage #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (wr_en_i) begin
      mem_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - DEPTH-entry fetch-to-decode instruction FIFO with PC tags and flush
// First-word fall-through from storage; full/empty derive from the occupancy counter only.
module instruction_queue
  import cpu_pkg::*;
#(
  parameter int DATA_WIDTH   = cpu_pkg::DATA_WIDTH,
  parameter int ADDR_WIDTH   = cpu_pkg::ADDR_WIDTH,
  parameter int DEPTH        = 4,
  parameter int OPCODE_WIDTH = cpu_pkg::OPCODE_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_instruction,
  input  logic [ADDR_WIDTH-1:0]   in_pc,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_instruction,
  output logic [ADDR_WIDTH-1:0]   out_pc,
  output logic [OPCODE_WIDTH-1:0] out_opcode,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = ADDR_WIDTH + DATA_WIDTH;

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, empty, push, pop;
  logic [ENT_W-1:0] head;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      // Simultaneous push and pop leaves occupancy unchanged.
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  iq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W),
    .PTR_W (PTR_W)
  ) u_storage (
    .clk       (clk),
    .reset     (reset),
    .wr_en_i   (push),
    .wr_addr_i (wr_ptr_q),
    .wr_data_i ({in_pc, in_instruction}),
    .rd_addr_i (rd_ptr_q),
    .rd_data_o (head)
  );

  assign out_pc          = head[ENT_W-1 -: ADDR_WIDTH];
  assign out_instruction = head[DATA_WIDTH-1:0];
  assign out_opcode      = out_instruction[DATA_WIDTH-1 -: OPCODE_WIDTH];
  assign count           = count_q;

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed scoreboard bench for instruction_queue
module tb_instruction_queue;
  import cpu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_instruction, in_pc, out_instruction, out_pc;
  logic [5:0]  out_opcode;
  logic [2:0]  count;

  int passed = 0;
  int failed = 0;
  int total  = 0;
  iq_entry_t sb[$];

  always #5 clk = ~clk;

  instruction_queue #(.DEPTH(4)) dut (
    .clk             (clk),
    .reset           (reset),
    .flush           (flush),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_instruction  (in_instruction),
    .in_pc           (in_pc),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_instruction (out_instruction),
    .out_pc          (out_pc),
    .out_opcode      (out_opcode),
    .count           (count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, resolve handshakes at negedge, return at next posedge+1.
  task automatic step(input logic iv, input logic [31:0] ins, input logic [31:0] pc,
                      input logic ordy, input logic fl);
    iq_entry_t e;
    in_valid = iv; in_instruction = ins; in_pc = pc; out_ready = ordy; flush = fl;
    @(negedge clk);
    if (!fl && ordy && out_valid) begin
      if (sb.size() == 0) chk("unexpected_pop", 64'(out_valid), 64'd0);
      else begin
        e = sb.pop_front();
        chk("out_instruction", 64'(out_instruction), 64'(e.instruction));
        chk("out_pc", 64'(out_pc), 64'(e.pc));
      end
    end
    if (!fl && iv && in_ready) begin
      e.pc = pc; e.instruction = ins;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    if (fl) sb.delete();
    in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_instruction = '0; in_pc = '0;
    repeat (2) @(posedge clk); #1;
    chk("rst_count", 64'(count), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_instruction", 64'(out_instruction), 64'd0);
    chk("rst_out_pc", 64'(out_pc), 64'd0);
    reset = 1'b0;

    // 1. asynchronous reset with three entries in flight
    for (int i = 0; i < 3; i++) step(1'b1, 32'h8400_0000 + 32'(i), 32'h40 + 32'(4*i), 1'b0, 1'b0);
    chk("t1_count_before", 64'(count), 64'd3);
    chk("t1_opcode_before", 64'(out_opcode), 64'h21);
    #2 reset = 1'b1;
    #1;
    chk("t1_count", 64'(count), 64'd0);
    chk("t1_out_valid", 64'(out_valid), 64'd0);
    chk("t1_in_ready", 64'(in_ready), 64'd1);
    chk("t1_out_opcode", 64'(out_opcode), 64'd0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
    sb.delete();

    // 2. fill to DEPTH, overflow attempt ignored, drain in order
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA100_0001 + 32'(i), 32'h100 + 32'(4*i), 1'b0, 1'b0);
    chk("t2_count_full", 64'(count), 64'd4);
    chk("t2_in_ready_full", 64'(in_ready), 64'd0);
    step(1'b1, 32'hA100_0005, 32'h110, 1'b0, 1'b0);
    chk("t2_count_overflow", 64'(count), 64'd4);
    for (int i = 0; i < 4; i++) step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t2_count_drained", 64'(count), 64'd0);
    chk("t2_out_valid_drained", 64'(out_valid), 64'd0);

    // 3. full queue: push and pop requested together, only the pop happens
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB200_0000 + 32'(i), 32'h300 + 32'(4*i), 1'b0, 1'b0);
    step(1'b1, 32'hB200_0099, 32'h3F0, 1'b1, 1'b0);
    chk("t3_count", 64'(count), 64'd3);
    chk("t3_in_ready", 64'(in_ready), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t3_count_two", 64'(count), 64'd2);

    // 4. steady push+pop at occupancy 2 across pointer wrap
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 32'hC300_0000 + 32'(i), 32'h400 + 32'(4*i), 1'b1, 1'b0);
      chk("t4_count", 64'(count), 64'd2);
    end

    // 5. flush discards concurrent push and pop
    step(1'b1, 32'hC3FF_0000, 32'h500, 1'b0, 1'b0);
    chk("t5_count_three", 64'(count), 64'd3);
    step(1'b1, 32'hDEAD_0000, 32'h600, 1'b1, 1'b1);
    chk("t5_count_flushed", 64'(count), 64'd0);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    step(1'b1, 32'hFC00_0000, 32'h700, 1'b0, 1'b0);
    chk("t5_out_opcode", 64'(out_opcode), 64'h3F);
    chk("t5_out_valid_after", 64'(out_valid), 64'd1);
    chk("t5_head_instruction", 64'(out_instruction), 64'hFC00_0000);
    chk("t5_count_one", 64'(count), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);

    // 6. pops requested while empty are ignored
    for (int i = 0; i < 5; i++) begin
      step(1'b0, '0, '0, 1'b1, 1'b0);
      chk("t6_count", 64'(count), 64'd0);
      chk("t6_out_valid", 64'(out_valid), 64'd0);
    end
    step(1'b1, 32'h5A5A_0001, 32'h800, 1'b0, 1'b0);
    chk("t6_head_instruction", 64'(out_instruction), 64'h5A5A_0001);
    chk("t6_head_pc", 64'(out_pc), 64'h800);
    chk("t6_count_one", 64'(count), 64'd1);
    step(1'b0, '0, '0, 1'b1, 1'b0);
    chk("t6_count_end", 64'(count), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
